qspi_line_arbiter: RTL



---
 rtl/qspi_xip_pkg.sv | 21 ++
 rtl/qspi_line_arbiter_rr_picker.sv | 31 +++
 rtl/qspi_line_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/qspi_xip_pkg.sv
// Shared definitions for the XIP line-fetch path.
// Holds the arbiter state encoding and line geometry constants/helpers.
package qspi_xip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam int LINE_SIZE_DEF = 128;
    localparam int LINE_BYTES    = LINE_SIZE_DEF / 8;
    localparam int LINE_OFF_W    = $clog2(LINE_BYTES);

    // Number of byte-offset bits inside a line of the given bit width.
    function automatic int line_off_w(int line_size);
        return $clog2(line_size / 8);
    endfunction

endpackage

// File: rtl/qspi_line_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req     - per-requester request levels
//   rr_ptr  - index with highest priority this round
//   gnt_oh  - one-hot winner (all zero when no request)
//   gnt_idx - binary index of the winner (0 when no request)
module rr_picker #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      rr_ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [1:0]      gnt_idx
);

    always_comb begin : pick
        int j;
        j       = 0;
        gnt_oh  = '0;
        gnt_idx = '0;
        // Scan from rr_ptr upwards with wrap; the first requester found wins.
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (req[j] && (gnt_oh == '0)) begin
                gnt_oh[j] = 1'b1;
                gnt_idx   = 2'(j);
            end
        end
    end

endmodule

// File: rtl/qspi_line_arbiter.sv
// Round-robin arbiter sharing one QSPI line reader between NREQ requesters.
// One fetch in flight; requesters asking for the same line as the fetch in
// flight at its completion edge are acked together with the winner.
// Ports:
//   HCLK, HRESETn       - clock, async active-low reset
//   req, req_addr       - per-requester request level and byte address
//   ack, line           - one-cycle ack mask and the last fetched line
//   gnt_id, busy, err   - last winner, not-idle flag, sticky spurious-done flag
//   fr_addr, fr_rd      - line-aligned fetch address and start pulse to reader
//   fr_done, fr_line    - reader completion pulse and line data
module qspi_line_arbiter
    import qspi_xip_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int LINE_SIZE = 128,
    parameter int AW        = 24
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      ack,
    output logic [LINE_SIZE-1:0] line,
    output logic [1:0]           gnt_id,
    output logic                 busy,
    output logic                 err,
    output logic [AW-1:0]        fr_addr,
    output logic                 fr_rd,
    input  logic                 fr_done,
    input  logic [LINE_SIZE-1:0] fr_line
);

    localparam int            OFF_W      = line_off_w(LINE_SIZE);
    localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << OFF_W;

    state_t               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [1:0]           gnt_id_q, gnt_id_d;
    logic [AW-1:0]        fr_addr_q, fr_addr_d;
    logic                 fr_rd_q, fr_rd_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic [LINE_SIZE-1:0] line_q, line_d;
    logic                 err_q, err_d;

    logic [AW-1:0]        req_line [NREQ];
    logic [NREQ-1:0]      pick_oh;
    logic [1:0]           pick_idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_line[i] = req_addr[i*AW +: AW] & ALIGN_MASK;
        end
    end

    rr_picker #(
        .NREQ (NREQ)
    ) u_rr_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_id_d  = gnt_id_q;
        fr_addr_d = fr_addr_q;
        line_d    = line_q;
        fr_rd_d   = 1'b0;
        ack_d     = '0;
        err_d     = err_q | (fr_done && (state_q != WAIT));

        case (state_q)
            IDLE: begin
                if (|pick_oh) begin
                    gnt_id_d = pick_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_oh[i]) begin
                            fr_addr_d = req_line[i];
                        end
                    end
                    rr_ptr_d = (pick_idx == 2'(NREQ - 1)) ? 2'd0 : pick_idx + 2'd1;
                    // Registered so the pulse lands exactly in the ISSUE cycle.
                    fr_rd_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (fr_done) begin
                    line_d = fr_line;
                    // Merge: anyone currently asking for this same line is served.
                    for (int j = 0; j < NREQ; j++) begin
                        ack_d[j] = req[j] && (req_line[j] == fr_addr_q);
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_id_q  <= '0;
            fr_addr_q <= '0;
            fr_rd_q   <= 1'b0;
            ack_q     <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_id_q  <= gnt_id_d;
            fr_addr_q <= fr_addr_d;
            fr_rd_q   <= fr_rd_d;
            ack_q     <= ack_d;
            line_q    <= line_d;
            err_q     <= err_d;
        end
    end

    assign ack     = ack_q;
    assign line    = line_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = (state_q != IDLE);
    assign err     = err_q;
    assign fr_addr = fr_addr_q;
    assign fr_rd   = fr_rd_q;

endmodule
